// File: rtl/shfl_pipe.sv
// Two-stage elastic shift/rotate unit. Stage 1 decodes the shift amount from B
// (marker or direct); stage 2 performs the shift or rotate into the output registers.
module shfl_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int OP_DIR = 2;
  localparam int OP_ROT = 1;
  localparam int OP_ENC = 0;

  // Marker mode: lowest set bit of B gives a 1-based amount; B==0 means no shift.
  function automatic logic [SHW-1:0] decode_amt(input logic [WIDTH-1:0] b,
                                                input logic             enc);
    logic [SHW-1:0] amt;
    amt = '0;
    if (enc) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (b[i]) amt = SHW'(i + 1);
      end
    end else begin
      amt = {1'b0, b[SHW-2:0]};
    end
    return amt;
  endfunction

  // Returns {carry, result}. The extra guard bit on the logical paths catches
  // the last bit shifted out, including the full-width case.
  function automatic logic [WIDTH:0] shift_op(input logic [WIDTH-1:0] a,
                                              input logic [SHW-1:0]   amt,
                                              input logic             dir,
                                              input logic             rot);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH:0]     ext;
    logic [SHW-2:0]     rot_amt;
    logic [WIDTH:0]     res;
    dbl     = '0;
    ext     = '0;
    rot_amt = amt[SHW-2:0];
    if (amt == '0) begin
      res = {1'b0, a};
    end else if (rot) begin
      if (dir) begin
        dbl = {a, a} >> rot_amt;
        res = {1'b0, dbl[WIDTH-1:0]};
      end else begin
        dbl = {a, a} << rot_amt;
        res = {1'b0, dbl[2*WIDTH-1:WIDTH]};
      end
    end else if (dir) begin
      ext = {a, 1'b0} >> amt;
      res = {ext[0], ext[WIDTH:1]};
    end else begin
      ext = {1'b0, a} << amt;
      res = ext;
    end
    return res;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [SHW-1:0]   amt_p1_q, amt_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic             dir_p1_q, dir_p1_d;
  logic             rot_p1_q, rot_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  logic             car_p2_q, car_p2_d;
  logic             zero_p2_q, zero_p2_d;

  logic             s2_free;
  logic             s1_adv;
  logic             in_xfer;
  logic [WIDTH:0]   shifted;

  always_comb begin
    s2_free  = !vld_p2_q || out_ready;
    s1_adv   = vld_p1_q && s2_free;
    in_ready = !rst && (!vld_p1_q || s1_adv);
    in_xfer  = in_valid && in_ready;
  end

  // Stage 0 -> 1: amount decode
  always_comb begin
    vld_p1_d = vld_p1_q;
    amt_p1_d = amt_p1_q;
    a_p1_d   = a_p1_q;
    dir_p1_d = dir_p1_q;
    rot_p1_d = rot_p1_q;
    if (in_xfer) begin
      vld_p1_d = 1'b1;
      amt_p1_d = decode_amt(in_b, in_op[OP_ENC]);
      a_p1_d   = in_a;
      dir_p1_d = in_op[OP_DIR];
      rot_p1_d = in_op[OP_ROT];
    end else if (s1_adv) begin
      vld_p1_d = 1'b0;
    end
  end

  // Stage 1 -> 2: shift/rotate into the output registers
  always_comb begin
    shifted   = shift_op(a_p1_q, amt_p1_q, dir_p1_q, rot_p1_q);
    vld_p2_d  = vld_p2_q;
    res_p2_d  = res_p2_q;
    car_p2_d  = car_p2_q;
    zero_p2_d = zero_p2_q;
    if (s1_adv) begin
      vld_p2_d  = 1'b1;
      res_p2_d  = shifted[WIDTH-1:0];
      car_p2_d  = shifted[WIDTH];
      zero_p2_d = (shifted[WIDTH-1:0] == '0);
    end else if (out_ready) begin
      vld_p2_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      res_p2_q  <= '0;
      car_p2_q  <= 1'b0;
      zero_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      res_p2_q  <= res_p2_d;
      car_p2_q  <= car_p2_d;
      zero_p2_q <= zero_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    amt_p1_q <= amt_p1_d;
    a_p1_q   <= a_p1_d;
    dir_p1_q <= dir_p1_d;
    rot_p1_q <= rot_p1_d;
  end

  assign out_valid  = vld_p2_q;
  assign out_result = res_p2_q;
  assign out_carry  = car_p2_q;
  assign out_zero   = zero_p2_q;

endmodule

// File: doc/shfl_pipe.md
Name: shfl_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle left-shift-by-marker unit.
- Operand A is shifted or rotated by an amount derived from operand B. The amount is either the 1-based index of the least-significant '1' in B, or a direct binary count.
- Left/right, logical/rotate modes are selectable per operation.
- Two-stage elastic pipeline with valid/ready handshake.
- Sits behind the ALU issue stage as a multi-cycle functional unit.

Parameters:
- WIDTH, 16, data width of A, B and result (power of two, >= 4).
- SHW, $clog2(WIDTH)+1, width of the internal shift amount; must represent 0..WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_a  in  WIDTH  data to be shifted.
- in_b  in  WIDTH  shift-amount source.
- in_op  in  3  {dir, rot, enc}.
  - dir: 0 = left, 1 = right.
  - rot: 0 = logical, 1 = rotate.
  - enc: 1 = marker-encoded amount, 0 = direct binary amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  WIDTH  shifted/rotated data.
- out_carry  out  1  last bit shifted out (logical modes); 0 for rotate and for amount 0.
- out_zero  out  1  out_result == 0.

Behaviour:
- Reset:
  - out_valid=0, out_result=0, out_carry=0, out_zero=0; stage-1 valid=0.
  - in_ready=1 from the cycle after rst deasserts; in_ready=0 while rst=1.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1 (amount decode), registered on input transfer:
  - enc=1, B != 0: amount = (index of lowest '1' in B) + 1, range 1..WIDTH.
  - enc=1, B == 0: amount = 0 (pass-through).
  - enc=0: amount = B[SHW-2:0], range 0..WIDTH-1; upper bits of B are ignored.
  - A and op are registered alongside the amount.
- Stage 2 (shift), registered into the output regs:
  - Logical left: result = A << amount, zero fill. Carry = A[WIDTH-amount] for amount >= 1.
  - Logical right: result = A >> amount, zero fill. Carry = A[amount-1] for amount >= 1.
  - Amount == WIDTH in logical mode: result = 0. Carry = A[0] (left) or A[WIDTH-1] (right).
  - Rotate: effective amount = amount mod WIDTH, so amount == WIDTH leaves A unchanged. Carry = 0.
  - Amount 0: result = A, carry = 0.
  - Zero flag is computed from the final result.
- Latency: exactly 2 cycles from input transfer to out_valid=1, absent back-pressure.
- Throughput: one operation per cycle while out_ready=1.
- Back-pressure:
  - Stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances into stage 2 only when stage 2 is empty or being drained the same cycle.
  - in_ready = !s1_valid || s1_advance (full-throughput elastic pipeline, no bubbles).
  - Capacity is 2 operations in flight; with out_ready=0, in_ready drops after 2 accepts.
  - out_result, out_carry and out_zero stay stable while out_valid && !out_ready.
- Simultaneous input accept and output drain in one cycle: both occur; no loss, no duplication.
- Reset asserted mid-operation: all in-flight operations are discarded; outputs return to reset values on the next edge.
- No combinational path from in_* to out_*. in_ready may depend combinationally on out_ready.
- Exact loop bounds only in decode logic: no unbounded loops, no state held in variables across evaluations.

Test Plan:
- Marker mode, WIDTH=16: A=0x0001, B=0x0004, op=left/logical/enc.
  - Expect out_result=0x0008, carry=0, zero=0, two cycles after accept.
- B=0 passthrough and MSB marker:
  - A=0xABCD, B=0, enc left -> 0xABCD, carry=0.
  - A=0x8001, B=0x8000, enc left logical -> amount 16: result=0x0000, carry=1, zero=1.
  - Same as above with rot=1 -> 0x8001.
- Direct amounts:
  - A=0x8421, B=0x0003, op=right/rotate/direct -> 0x3084, carry=0.
  - A=0x00F0, B=0x0005, right/logical/direct -> 0x0007, carry=1.
- Back-pressure:
  - Stream 4 ops with out_ready=0.
  - Expect in_ready=0 after 2 accepts and held outputs stable.
  - Release out_ready; expect all 4 results in order with no duplication or loss.
- Full throughput: 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles starting 2 cycles after the first accept.
- Reset mid-stream:
  - Assert rst with 2 ops in flight.
  - Expect out_valid=0, out_result=0, in_ready=0 during reset.
  - After release, the first new op returns the correct result with latency 2.
